counter_cmd_ctrl: RTL and testbench
===================================

Name: counter_cmd_ctrl

Overview:
- Command sequencer placed directly upstream of the 8-bit up/down counter.
- Accepts LOAD / RUN-UP / RUN-DOWN / NOP commands over a valid/ready handshake.
- Drives the counter's enable, set, direction and load-value inputs cycle-accurately, and reports completion.

Parameters:
- WIDTH, 8, width of the counter load value and of counter_val_out.
- LEN_W, 8, width of the run-length field; RUN commands use the low LEN_W bits of cmd_data_in.

Ports:
- clk_in  input  1  clock, rising edge.
- nrst_in  input  1  asynchronous, active-low reset.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  block can accept a command this cycle.
- cmd_op_in  input  2  00 NOP, 01 LOAD, 10 RUN_UP, 11 RUN_DOWN.
- cmd_data_in  input  WIDTH  load value (LOAD) or run length N (RUN_*).
- abort_in  input  1  terminate an active run.
- ovf_in  input  1  overflow flag from the counter (used only with the optional feature).
- en_ctl_out  output  1  counter enable.
- set_ctrl_out  output  1  counter synchronous load strobe.
- up_ctrl_out  output  1  counter direction; 1 = up.
- counter_val_out  output  WIDTH  load value presented to the counter.
- busy_out  output  1  high in any state other than IDLE.
- done_out  output  1  one-cycle completion pulse.
- status_ovf_out  output  1  run was stopped by overflow (optional feature).

Behaviour:
- Reset: clock is clk_in; reset is asynchronous, active-low on nrst_in. While nrst_in is low:
  - state = IDLE.
  - en_ctl_out, set_ctrl_out, up_ctrl_out, busy_out, done_out, status_ovf_out = 0; counter_val_out = 0.
  - cmd_ready_out = 1.
- Output timing: all outputs are registered, except cmd_ready_out = (state == IDLE) and busy_out = (state != IDLE).
- Handshake: a command is accepted on the rising edge where cmd_valid_in && cmd_ready_out. Outputs reflect the command from the next cycle (latency 1). cmd_valid_in is ignored when ready is low. Inputs need only be stable in the acceptance cycle.
- States:
  - IDLE:
    - NOP -> DONE.
    - LOAD -> LOAD_S; latch cmd_data_in into counter_val_out.
    - RUN_UP / RUN_DOWN with N == 0 -> DONE; enable is never asserted.
    - RUN_UP / RUN_DOWN with N > 0 -> RUN; latch N into the remaining count rem; up_ctrl_out = op[0] inverted (RUN_UP -> 1).
  - LOAD_S: set_ctrl_out = 1 for exactly one cycle, en_ctl_out = 0 -> DONE. abort_in is ignored.
  - RUN:
    - en_ctl_out = 1 for exactly N consecutive cycles; rem decrements each cycle; when rem == 1 -> DONE.
    - up_ctrl_out is held constant for the whole run.
    - set_ctrl_out = 0.
  - DONE: done_out = 1 for one cycle, en_ctl_out = 0 -> IDLE. The next command can be accepted in the following cycle.
- Abort:
  - abort_in high in RUN: en_ctl_out drops on the next cycle, state -> DONE, remaining count discarded.
  - abort_in high together with a command in IDLE: the command is accepted; abort is ignored.
- Values held between commands:
  - N = 2^LEN_W - 1 gives a full-length run with no wrap of rem.
  - counter_val_out holds its last LOAD value.
  - up_ctrl_out holds its last direction.
- Reset mid-run: all outputs return immediately (asynchronously) to their reset values; the in-flight command is lost.
- en_ctl_out and set_ctrl_out are never high in the same cycle.

Optional Feature:
- Macro: COUNTER_CMD_CTRL_OVF_STOP_EN.
- Defined:
  - ovf_in sampled high while in RUN ends the run like an abort.
  - status_ovf_out is set in the DONE cycle and stays high until the next command is accepted, then clears.
  - ovf_in and abort_in in the same cycle: status_ovf_out = 1.
- Undefined: ovf_in is ignored; status_ovf_out is tied to 0.

Decomposition:
- Package counter_ctrl_pkg:
  - 2-bit op encodings OP_NOP, OP_LOAD, OP_RUN_UP, OP_RUN_DOWN.
  - State enum IDLE, LOAD_S, RUN, DONE.
  - Default WIDTH / LEN_W constants.
- One natural sub-module, run_len_cnt: LEN_W-bit loadable down-counter with load, dec, clear inputs and a last (rem == 1) output.

Test Plan:
- Reset, then LOAD 0x5A: set_ctrl_out high exactly 1 cycle with counter_val_out = 0x5A, en low; done_out pulses the following cycle.
- RUN_UP N = 3: en_ctl_out high exactly 3 cycles with up_ctrl_out = 1; done_out on the 4th cycle; cmd_ready_out low throughout.
- RUN_DOWN N = 0: no enable cycle; done_out one cycle after acceptance; up_ctrl_out = 0.
- RUN_UP N = 10 with abort_in at the 4th enable cycle: exactly 4 enable cycles, then done_out; a new command is accepted 1 cycle later.
- nrst_in pulsed low mid-RUN (N = 20): outputs zero immediately and cmd_ready_out = 1; a subsequent LOAD 0x01 works normally.
- With COUNTER_CMD_CTRL_OVF_STOP_EN: RUN_UP N = 50 with ovf_in high at cycle 7 -> 7 enable cycles, done_out, status_ovf_out = 1 until the next accept. Without the macro: 50 enable cycles, status_ovf_out = 0.

Source files
------------

// File: rtl/counter_cmd_ctrl_pkg.sv
// Shared encodings and default widths for the counter command sequencer.
package counter_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_LOAD     = 2'b01,
    OP_RUN_UP   = 2'b10,
    OP_RUN_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_S = 2'b01,
    RUN    = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/counter_cmd_ctrl_if.sv
// Command valid/ready channel into the counter command sequencer.
interface counter_cmd_ctrl_if #(
  parameter int unsigned WIDTH = counter_ctrl_pkg::WIDTH_DEF
) ();

  logic             cmd_valid_in;
  logic             cmd_ready_out;
  logic [1:0]       cmd_op_in;
  logic [WIDTH-1:0] cmd_data_in;

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_data_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_data_in,
    output cmd_ready_out
  );

endinterface

// File: rtl/counter_cmd_ctrl_run_len_cnt.sv
// Loadable run-length down-counter; last_c flags the final cycle of a run.
module run_len_cnt #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk_in,
  input  logic             nrst_in,
  input  logic             load,
  input  logic             dec,
  input  logic             clear,
  input  logic [LEN_W-1:0] load_val,
  output logic             last_c
);

  logic [LEN_W-1:0] rem_q;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rem_q <= '0;
    end else if (clear) begin
      rem_q <= '0;
    end else if (load) begin
      rem_q <= load_val;
    end else if (dec) begin
      rem_q <= rem_q - LEN_W'(1);
    end
  end

  assign last_c = (rem_q == LEN_W'(1));

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command sequencer driving the up/down counter's enable/set/direction/load inputs.
// Optional overflow stop: COUNTER_CMD_CTRL_OVF_STOP_EN.
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk_in,
  input  logic              nrst_in,
  counter_cmd_ctrl_if.slave cmd,
  input  logic              abort_in,
  input  logic              ovf_in,
  output logic              en_ctl_out,
  output logic              set_ctrl_out,
  output logic              up_ctrl_out,
  output logic [WIDTH-1:0]  counter_val_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              status_ovf_out
);

  state_e           state_q, state_d;
  logic             en_d, set_d, up_d, done_d;
  logic [WIDTH-1:0] val_d;
  logic             cnt_load, cnt_dec, cnt_clear, last_c;
  logic             accept_c, stop_c, ovf_stop_c;
  logic [LEN_W-1:0] len_c;

  assign accept_c          = cmd.cmd_valid_in && (state_q == IDLE);
  assign cmd.cmd_ready_out = (state_q == IDLE);
  assign busy_out          = (state_q != IDLE);
  assign len_c             = cmd.cmd_data_in[LEN_W-1:0];
  assign stop_c            = abort_in || ovf_stop_c;

`ifdef COUNTER_CMD_CTRL_OVF_STOP_EN
  assign ovf_stop_c = ovf_in;

  // Sticky overflow status: raised entering DONE, cleared by the next accepted command.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      status_ovf_out <= 1'b0;
    end else if (accept_c) begin
      status_ovf_out <= 1'b0;
    end else if ((state_q == RUN) && ovf_in) begin
      status_ovf_out <= 1'b1;
    end
  end
`else
  logic ovf_unused;
  assign ovf_unused     = ovf_in;
  assign ovf_stop_c     = 1'b0;
  assign status_ovf_out = 1'b0;
`endif

  run_len_cnt #(.LEN_W(LEN_W)) u_run_len_cnt (
    .clk_in   (clk_in),
    .nrst_in  (nrst_in),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .load_val (len_c),
    .last_c   (last_c)
  );

  // Next state and next values of the registered counter controls.
  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    set_d     = 1'b0;
    done_d    = 1'b0;
    up_d      = up_ctrl_out;
    val_d     = counter_val_out;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          case (op_e'(cmd.cmd_op_in))
            OP_LOAD: begin
              state_d = LOAD_S;
              set_d   = 1'b1;
              val_d   = cmd.cmd_data_in;
            end
            OP_RUN_UP, OP_RUN_DOWN: begin
              up_d = ~cmd.cmd_op_in[0];
              if (len_c == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d  = RUN;
                en_d     = 1'b1;
                cnt_load = 1'b1;
              end
            end
            default: begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      LOAD_S: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      RUN: begin
        if (stop_c || last_c) begin
          state_d   = DONE;
          done_d    = 1'b1;
          cnt_clear = 1'b1;
        end else begin
          en_d    = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q         <= IDLE;
      en_ctl_out      <= 1'b0;
      set_ctrl_out    <= 1'b0;
      up_ctrl_out     <= 1'b0;
      done_out        <= 1'b0;
      counter_val_out <= '0;
    end else begin
      state_q         <= state_d;
      en_ctl_out      <= en_d;
      set_ctrl_out    <= set_d;
      up_ctrl_out     <= up_d;
      done_out        <= done_d;
      counter_val_out <= val_d;
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Scoreboard bench for counter_cmd_ctrl: directed scenarios then randomized commands.
module tb_counter_cmd_ctrl;
  import counter_ctrl_pkg::*;

`ifdef COUNTER_CMD_CTRL_OVF_STOP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       nrst_in;
  logic       abort_in, ovf_in;
  logic       en_ctl_out, set_ctrl_out, up_ctrl_out, busy_out, done_out, status_ovf_out;
  logic [7:0] counter_val_out;

  counter_cmd_ctrl_if #(.WIDTH(8)) cmd_if ();

  counter_cmd_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
    .clk_in          (clk_in),
    .nrst_in         (nrst_in),
    .cmd             (cmd_if),
    .abort_in        (abort_in),
    .ovf_in          (ovf_in),
    .en_ctl_out      (en_ctl_out),
    .set_ctrl_out    (set_ctrl_out),
    .up_ctrl_out     (up_ctrl_out),
    .counter_val_out (counter_val_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .status_ovf_out  (status_ovf_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected outcome of one command, measured from its acceptance edge.
  typedef struct {
    int en_n;
    int set_n;
    int done_cyc;
    bit up;
    int val;
    bit sts;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_up     = 1'b0;
  int   m_val    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command; mode bit0 pulses abort, bit1 pulses ovf, during enable cycle k.
  task automatic issue(input logic [1:0] op, input int data, input int mode, input int k,
                       input bit idle_abort);
    exp_t e;
    int   wd;
    bit   stop;
    wd = 0;
    while (!cmd_if.cmd_ready_out && wd < 1000) begin
      @(posedge clk_in); #1;
      wd++;
    end
    if (!cmd_if.cmd_ready_out) begin
      check("ready_timeout", 0, 1);
      return;
    end
    e.en_n = 0; e.set_n = 0; e.done_cyc = 1; e.sts = 1'b0;
    if (op == OP_LOAD) begin
      m_val = data;
      e.set_n = 1;
      e.done_cyc = 2;
    end else if (op == OP_RUN_UP || op == OP_RUN_DOWN) begin
      m_up = (op == OP_RUN_UP);
      stop = (mode == 1) || (mode == 3) || (OVF_EN && mode == 2);
      e.en_n = (data > 0 && stop && k < data) ? k : data;
      e.done_cyc = e.en_n + 1;
      e.sts = OVF_EN && (data > 0) && (mode >= 2);
    end
    e.up  = m_up;
    e.val = m_val;
    sb_q.push_back(e);
    cmd_if.cmd_valid_in = 1'b1;
    cmd_if.cmd_op_in    = op;
    cmd_if.cmd_data_in  = 8'(data);
    abort_in            = idle_abort;
    @(posedge clk_in); #1;
    cmd_if.cmd_valid_in = 1'b0;
    cmd_if.cmd_op_in    = 2'($urandom);
    cmd_if.cmd_data_in  = 8'($urandom);
    abort_in            = 1'b0;
    if ((op == OP_RUN_UP || op == OP_RUN_DOWN) && data > 0 && mode != 0) begin
      repeat (k - 1) begin
        @(posedge clk_in); #1;
      end
      abort_in = mode[0];
      ovf_in   = mode[1];
      @(posedge clk_in); #1;
      abort_in = 1'b0;
      ovf_in   = 1'b0;
    end
  endtask

  // Monitor: count enable/set cycles per command and compare on each done pulse.
  int pend = 0, cyc = 0, en_n = 0, set_n = 0;
  bit ready_chk = 1'b0, last_sts = 1'b0;

  always @(negedge clk_in) begin
    exp_t e;
    if (!nrst_in) begin
      pend = 0; ready_chk = 1'b0; last_sts = 1'b0;
      sb_q.delete();
    end else begin
      if (en_ctl_out && set_ctrl_out) check("en_set_exclusive", 1, 0);
      if (pend != 0) begin
        cyc++;
        if (en_ctl_out) en_n++;
        if (set_ctrl_out) set_n++;
        if (en_ctl_out && sb_q.size() > 0) check("run_dir", int'(up_ctrl_out), int'(sb_q[0].up));
        if (set_ctrl_out && sb_q.size() > 0) check("load_val", int'(counter_val_out), sb_q[0].val);
        check("ready_low_busy", int'({cmd_if.cmd_ready_out, busy_out}), 1);
        if (done_out) begin
          if (sb_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("en_cycles", en_n, e.en_n);
            check("set_cycles", set_n, e.set_n);
            check("done_latency", cyc, e.done_cyc);
            check("dir_at_done", int'(up_ctrl_out), int'(e.up));
            check("val_at_done", int'(counter_val_out), e.val);
            check("sts_at_done", int'(status_ovf_out), int'(e.sts));
            last_sts = e.sts;
          end
          pend = 0;
          ready_chk = 1'b1;
        end else begin
          check("sts_cleared", int'(status_ovf_out), 0);
        end
      end else begin
        if (done_out) check("spurious_done", 1, 0);
        if (ready_chk) check("ready_after_done", int'(cmd_if.cmd_ready_out), 1);
        ready_chk = 1'b0;
        check("sts_held", int'(status_ovf_out), int'(last_sts));
      end
      if (cmd_if.cmd_valid_in && cmd_if.cmd_ready_out) begin
        pend = 1; cyc = 0; en_n = 0; set_n = 0;
      end
    end
  end

  initial begin
    int op, n, mode, k, r, wd;
    nrst_in = 1'b0;
    abort_in = 1'b0;
    ovf_in = 1'b0;
    cmd_if.cmd_valid_in = 1'b0;
    cmd_if.cmd_op_in = 2'b00;
    cmd_if.cmd_data_in = 8'h00;
    #2;
    check("rst_ready", int'(cmd_if.cmd_ready_out), 1);
    check("rst_outs", int'({en_ctl_out, set_ctrl_out, up_ctrl_out, busy_out, done_out,
                           status_ovf_out, counter_val_out}), 0);
    repeat (2) @(posedge clk_in);
    #1 nrst_in = 1'b1;

    issue(OP_LOAD, 8'h5A, 0, 0, 1'b0);
    issue(OP_RUN_UP, 3, 0, 0, 1'b0);
    issue(OP_RUN_DOWN, 0, 0, 0, 1'b0);
    issue(OP_RUN_UP, 10, 1, 4, 1'b0);
    issue(OP_NOP, 0, 0, 0, 1'b1);
    issue(OP_RUN_UP, 255, 0, 0, 1'b0);

    // Reset pulse in the middle of a run.
    issue(OP_RUN_UP, 20, 0, 0, 1'b0);
    repeat (4) begin
      @(posedge clk_in); #1;
    end
    #2 nrst_in = 1'b0;
    #1;
    check("midrst_ready", int'(cmd_if.cmd_ready_out), 1);
    check("midrst_outs", int'({en_ctl_out, set_ctrl_out, up_ctrl_out, busy_out, done_out,
                              status_ovf_out, counter_val_out}), 0);
    m_up = 1'b0;
    m_val = 0;
    repeat (2) @(posedge clk_in);
    #1 nrst_in = 1'b1;

    issue(OP_LOAD, 8'h01, 0, 0, 1'b0);
    issue(OP_RUN_UP, 50, 2, 7, 1'b0);
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    issue(OP_NOP, 0, 0, 0, 1'b0);
    issue(OP_RUN_DOWN, 5, 3, 2, 1'b0);

    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (op == int'(OP_LOAD)) n = int'($urandom_range(0, 255));
      else if (r == 0) n = 0;
      else if (r == 9) n = int'($urandom_range(100, 255));
      else n = int'($urandom_range(1, 30));
      mode = int'($urandom_range(0, 3));
      k = (n > 0) ? int'($urandom_range(1, n)) : 0;
      issue(2'(op), n, mode, k, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_in); #1;
      end
    end

    wd = 0;
    while ((sb_q.size() != 0 || busy_out) && wd < 2000) begin
      @(posedge clk_in); #1;
      wd++;
    end
    check("drain", sb_q.size(), 0);
    repeat (2) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
